// File: rtl/mbus_ice_sl_frame_buffer.sv
// Slave-side MBus frame buffer: stores received frames (optional time tag, payload,
// tail-marked length terminator) in a circular RAM that the host drains via sl_* bus.
module mbus_ice_sl_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int TAG_EN = 1,
    parameter int ARB_W  = 2,
    parameter int ARB_ID = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_valid,
    input  logic              in_frame_valid,
    input  logic [DATA_W-1:0] global_counter,
    input  logic [ADDR_W-1:0] sl_addr,
    output logic [DATA_W:0]   sl_data,
    output logic [ADDR_W-1:0] sl_tail,
    input  logic              sl_latch_tail,
    output logic [ARB_W-1:0]  sl_arb_request,
    input  logic [ARB_W-1:0]  sl_arb_grant,
    output logic              sl_overflow
);

    // state  | meaning
    // S_IDLE | no frame in progress; a high in_frame_valid is a frame rise
    // S_RECV | inside a frame, words are being stored
    // S_DROP | inside a frame that is being discarded (overflow or reset mid-frame)

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LEN_W = 16;
    localparam logic [ARB_W-1:0] ARB_CODE = ARB_W'(ARB_ID);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   start_ptr;
    logic [ADDR_W-1:0]   commit_ptr;
    logic [LEN_W-1:0]    len;
    logic [DATA_W:0]     mem [DEPTH];

    logic                rise;
    logic                fall;
    logic                data_ev;
    logic                full;
    logic                wr_req;
    logic                wr_en;
    logic                ovf;
    logic                latch_ok;
    logic [DATA_W:0]     wr_word;
    logic [ADDR_W-1:0]   wr_ptr_inc;
    logic [ADDR_W-1:0]   rd_span;
    logic [ADDR_W-1:0]   commit_span;

    always_comb begin
        wr_ptr_inc  = wr_ptr + 1'b1;
        full        = (wr_ptr_inc == sl_tail);
        rise        = in_frame_valid && (state == S_IDLE);
        fall        = !in_frame_valid && (state == S_RECV);
        data_ev     = in_data_valid && in_frame_valid && (state == S_RECV);
        wr_req      = 1'b0;
        wr_word     = '0;
        if (rise) begin
            if (TAG_EN != 0) begin
                wr_req  = 1'b1;
                wr_word = {1'b0, global_counter};
            end
        end else if (data_ev) begin
            wr_req  = 1'b1;
            wr_word = {1'b0, in_data};
        end else if (fall) begin
            wr_req  = 1'b1;
            wr_word = {1'b1, DATA_W'(len)};
        end
        wr_en       = wr_req && !full;
        ovf         = wr_req && full;
        rd_span     = sl_addr - sl_tail;
        commit_span = commit_ptr - sl_tail;
        latch_ok    = sl_latch_tail && (sl_arb_grant == ARB_CODE) && (rd_span <= commit_span);
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sl_data <= '0;
        end else begin
            sl_data <= mem[sl_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // A frame still open across reset is discarded until its fall.
            state          <= in_frame_valid ? S_DROP : S_IDLE;
            wr_ptr         <= '0;
            start_ptr      <= '0;
            commit_ptr     <= '0;
            len            <= '0;
            sl_tail        <= '0;
            sl_arb_request <= '0;
            sl_overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_frame_valid) begin
                        start_ptr <= wr_ptr;
                        len       <= '0;
                        state     <= ovf ? S_DROP : S_RECV;
                    end
                end
                S_RECV: begin
                    if (!in_frame_valid) begin
                        state <= S_IDLE;
                    end else if (ovf) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!in_frame_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (ovf && !rise) begin
                wr_ptr <= start_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr_inc;
            end

            if (data_ev && wr_en && (len != '1)) begin
                len <= len + 1'b1;
            end

            if (fall && wr_en) begin
                commit_ptr <= wr_ptr_inc;
            end

            if (latch_ok) begin
                sl_tail <= sl_addr;
            end

            if (ovf) begin
                sl_overflow <= 1'b1;
            end else if (latch_ok) begin
                sl_overflow <= 1'b0;
            end

            sl_arb_request <= (commit_ptr != sl_tail) ? ARB_CODE : '0;
        end
    end

endmodule

// File: doc/mbus_ice_sl_frame_buffer.md
Name: mbus_ice_sl_frame_buffer

Overview:
Parametrised slave-side frame buffer for the ICE MBus layer wrapper. It collects received MBus frames (byte stream plus frame-valid envelope) into a circular RAM. Each frame is optionally prefixed with a global-counter time tag and always closed with a tail-marked terminator word. Stored frames are exposed to the host over the sl_addr / sl_data / sl_tail / sl_latch_tail / arbitration bus. New generalisations:
- configurable data width, depth and arbiter ID;
- whole-frame drop on overflow, instead of truncation.

Parameters:
DATA_W, 8, payload word width; stored word is DATA_W+1 bits, and the MSB is the end-of-frame marker.
ADDR_W, 9, buffer address width; DEPTH = 2^ADDR_W words, of which DEPTH-1 are usable.
TAG_EN, 1, 1 = write a {0, global_counter} word before each frame's first data word.
ARB_W, 2, arbitration request/grant width.
ARB_ID, 2, code driven on sl_arb_request and matched on sl_arb_grant.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high.
in_data  in  DATA_W  received data word.
in_data_valid  in  1  one-cycle strobe; in_data is written when high.
in_frame_valid  in  1  high for the duration of a frame; the falling edge ends the frame.
global_counter  in  DATA_W  time tag, sampled on the frame rising edge.
sl_addr  in  ADDR_W  host read address.
sl_data  out  DATA_W+1  registered read data: mem[sl_addr], 1-cycle latency.
sl_tail  out  ADDR_W  host-consumed pointer.
sl_latch_tail  in  1  host commits sl_addr as the new sl_tail.
sl_arb_request  out  ARB_W  ARB_ID while committed unread frames exist, else 0.
sl_arb_grant  in  ARB_W  host grant.
sl_overflow  out  1  sticky frame-dropped flag.

Behaviour:
- Reset values: wr_ptr = start_ptr = commit_ptr = sl_tail = 0; sl_data = 0; sl_arb_request = 0; sl_overflow = 0; drop = 0; len = 0; fv_d = 0. RAM contents are not reset.
- Reset mid-frame: the partial frame is discarded.
  - If in_frame_valid is still high after reset release, the buffer enters DROP state until in_frame_valid falls.
  - No terminator is written for that frame, and sl_overflow is NOT set.
- Pointers are ADDR_W bits and wrap modulo DEPTH. Full condition: wr_ptr+1 == sl_tail.
- RAM has a single write port, one word per cycle. Write sources in priority order:
  - Rise cycle (in_frame_valid & !fv_d): start_ptr <= wr_ptr; len <= 0. If TAG_EN, write {0, global_counter}. in_data_valid is ignored in the rise cycle (protocol rule).
  - Data: in_data_valid & in_frame_valid & fv_d & !drop writes {0, in_data}, wr_ptr++, len++ (16-bit, saturating).
  - Fall cycle (!in_frame_valid & fv_d & !drop): write terminator {1, len[DATA_W-1:0]}; commit_ptr <= wr_ptr+1.
  - in_data_valid with in_frame_valid low: ignored.
- Overflow: any write attempted while full (tag, data or terminator):
  - wr_ptr <= start_ptr; drop <= 1; sl_overflow <= 1; commit_ptr is unchanged.
  - drop stays set until the next fall cycle, which clears it and writes nothing.
  - A new frame starts normally at the next rise.
- sl_overflow clears on an accepted sl_latch_tail, unless a new overflow occurs in the same cycle (set wins).
- Host side:
  - sl_data <= mem[sl_addr] every cycle. This read is independent of grant.
  - sl_latch_tail is accepted only when sl_arb_grant == ARB_ID and (sl_addr - sl_tail) <= (commit_ptr - sl_tail), both mod DEPTH. Accepted: sl_tail <= sl_addr. Otherwise it is ignored and no state changes.
  - The host reads through the word with MSB = 1, then latches sl_addr = terminator address + 1.
- sl_arb_request is registered: ARB_ID in the cycle after commit_ptr != sl_tail holds, else 0.
  - A commit and a latch in the same cycle are both applied.
  - Request falls the cycle after sl_tail catches commit_ptr.
- Empty frame (rise then fall, no data): [tag], then terminator {1, 0}.

Test Plan:
(DATA_W=8, ADDR_W=4, TAG_EN=1, ARB_ID=2)
1. Basic frame: global_counter=0x01; frame 0x62, 0x0a, 0x08 -> mem[0..4] = 0x001, 0x062, 0x00a, 0x008, 0x103; commit_ptr=5; sl_arb_request=2 one cycle later.
2. Readout and latch: grant=2; read sl_addr 0..4 with 1-cycle latency; latch sl_addr=5 -> sl_tail=5; sl_arb_request=0 next cycle.
3. Overflow: 14-byte frame (needs 16 words > 15 free) -> sl_overflow=1, wr_ptr restored to 5, request stays 0. Then a 2-byte frame 0xde, 0xad -> terminator 0x102, request=2. An accepted latch clears sl_overflow.
4. Illegal latch: with grant=0, latch -> sl_tail unchanged. With grant=2 and sl_addr beyond commit_ptr -> ignored.
5. Wrap-around: sl_tail=wr_ptr=12; 5-byte frame -> words land at 12..15, 0..1, terminator 0x105 at address 2; commit_ptr=3; readback correct.
6. Reset mid-frame: reset after 2 data bytes, in_frame_valid held high, 3 more bytes sent, then fall -> nothing written, pointers 0, request 0, sl_overflow 0. The next frame is stored at address 0.
